// File: rtl/ami_spi_pkg.sv
// ============================================================================
// Module   : ami_spi_pkg
// Brief    : Shared state encoding and frame-field constants for the AMI SPI responder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ami_spi_pkg;

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_CMD       = 3'd2,
        S_DATA      = 3'd3,
        S_DONE      = 3'd4,
        S_OVERRUN   = 3'd5
    } state_e;

    localparam int   CMD_BITS         = 8;
    localparam logic RW_READ          = 1'b1;
    localparam int   ADDR_FIELD_WIDTH = 7;

    // True when the 7-bit address field selects an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_FIELD_WIDTH-1:0] addr,
                                           input int aw);
        return (32'(addr) >> aw) == 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_input_sync.sv
// ============================================================================
// Module   : spi_input_sync
// Brief    : Multi-flop synchronizer with rise/fall detection on the synced level.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_input_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_sync = sync_q[STAGES-1];
    assign o_rise = sync_q[STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/ami_spi_responder.sv
// ============================================================================
// Module   : ami_spi_responder
// Brief    : Oversampling SPI mode-0 slave decoding R/nW+addr+data frames into a register file.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ami_spi_responder
    import ami_spi_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 16'h0000
) (
    input  logic                                   sysClk,
    input  logic                                   sysReset,
    input  logic                                   SPI_CLK,
    input  logic                                   SPI_CSB,
    input  logic                                   SPI_SDI,
    output logic                                   SPI_SDO,
    output logic                                   SPI_SDO_OE,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  regFile,
    output logic                                   wrStrobe,
    output logic [ADDR_WIDTH-1:0]                  wrAddr,
    output logic                                   frameError,
    output logic [15:0]                            frameCount
);

    localparam int NUM_REGS   = 2**ADDR_WIDTH;
    localparam int FRAME_BITS = CMD_BITS + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Only SCLK edges matter; its synced level is intentionally left unused.
    logic sclk_sync_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic csb_sync;
    logic csb_rise;
    logic csb_fall;
    logic sdi_sync;

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (sysClk),
        .rst     (sysReset),
        .i_async (SPI_CLK),
        .o_sync  (sclk_sync_unused),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_csb_sync (
        .clk     (sysClk),
        .rst     (sysReset),
        .i_async (SPI_CSB),
        .o_sync  (csb_sync),
        .o_rise  (csb_rise),
        .o_fall  (csb_fall)
    );

    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_d;

    always_comb begin
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], SPI_SDI};
    end

    assign sdi_sync = sdi_sync_q[SYNC_STAGES-1];

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]           cmd_shift_q, cmd_shift_d;
    logic                          rw_q, rw_d;
    logic [ADDR_FIELD_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]         data_shift_q, data_shift_d;
    logic [DATA_WIDTH-1:0]         out_shift_q, out_shift_d;
    logic                          sdo_q, sdo_d;
    logic                          oe_q, oe_d;
    logic                          wr_strobe_q, wr_strobe_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic                          frame_err_q, frame_err_d;
    logic [15:0]                   frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0]         regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]         regs_d [NUM_REGS];
    logic [CMD_BITS-1:0]           cmd_next;
    logic                          commit;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_shift_d  = cmd_shift_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_shift_d = data_shift_q;
        out_shift_d  = out_shift_q;
        sdo_d        = sdo_q;
        oe_d         = oe_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        commit       = 1'b0;
        cmd_next     = {cmd_shift_q[CMD_BITS-2:0], sdi_sync};

        // CSB rising is tested before SCLK edges so a coincident edge is dropped.
        unique case (state_q)
            S_WAIT_IDLE: begin
                if (csb_sync) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (csb_fall) begin
                    bit_cnt_d    = '0;
                    cmd_shift_d  = '0;
                    data_shift_d = '0;
                    out_shift_d  = '0;
                    sdo_d        = 1'b0;
                    oe_d         = 1'b1;
                    state_d      = S_CMD;
                end
            end
            S_CMD: begin
                if (csb_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (sclk_rise) begin
                    cmd_shift_d = cmd_next;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        rw_d   = cmd_next[CMD_BITS-1];
                        addr_d = cmd_next[ADDR_FIELD_WIDTH-1:0];
                        if (cmd_next[CMD_BITS-1] == RW_READ &&
                            addr_in_range(cmd_next[ADDR_FIELD_WIDTH-1:0], ADDR_WIDTH)) begin
                            out_shift_d = regs_q[cmd_next[ADDR_WIDTH-1:0]];
                        end else begin
                            out_shift_d = '0;
                        end
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (csb_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (sclk_rise) begin
                    data_shift_d = {data_shift_q[DATA_WIDTH-2:0], sdi_sync};
                    bit_cnt_d    = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = S_DONE;
                    end
                end else if (sclk_fall) begin
                    sdo_d       = out_shift_q[DATA_WIDTH-1];
                    out_shift_d = out_shift_q << 1;
                end
            end
            S_DONE: begin
                if (csb_rise) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (rw_q != RW_READ && addr_in_range(addr_q, ADDR_WIDTH)) begin
                        commit      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q[ADDR_WIDTH-1:0];
                    end
                    state_d = S_IDLE;
                end else if (sclk_rise) begin
                    sdo_d   = 1'b0;
                    state_d = S_OVERRUN;
                end else if (sclk_fall) begin
                    // Shift register is drained by now, so this presents 0.
                    sdo_d       = out_shift_q[DATA_WIDTH-1];
                    out_shift_d = out_shift_q << 1;
                end
            end
            S_OVERRUN: begin
                sdo_d = 1'b0;
                if (csb_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
            end
        endcase

        if (csb_sync) begin
            oe_d  = 1'b0;
            sdo_d = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[addr_q[ADDR_WIDTH-1:0]] = data_shift_q;
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            sdi_sync_q   <= '0;
            state_q      <= S_WAIT_IDLE;
            bit_cnt_q    <= '0;
            cmd_shift_q  <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_shift_q <= '0;
            out_shift_q  <= '0;
            sdo_q        <= 1'b0;
            oe_q         <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            sdi_sync_q   <= sdi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_shift_q  <= cmd_shift_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_shift_q <= data_shift_d;
            out_shift_q  <= out_shift_d;
            sdo_q        <= sdo_d;
            oe_q         <= oe_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
            regs_q       <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regFile[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign SPI_SDO    = sdo_q;
    assign SPI_SDO_OE = oe_q;
    assign wrStrobe   = wr_strobe_q;
    assign wrAddr     = wr_addr_q;
    assign frameError = frame_err_q;
    assign frameCount = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ami_spi_responder.sv
// ============================================================================
// Module   : tb_ami_spi_responder
// Brief    : Table-driven SPI master bench for ami_spi_responder plus overrun/reset sequences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ami_spi_responder;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int HALF = 8;   // sysClk cycles per SCLK half-period

    logic            sysClk   = 1'b0;
    logic            sysReset = 1'b1;
    logic            SPI_CLK  = 1'b0;
    logic            SPI_CSB  = 1'b1;
    logic            SPI_SDI  = 1'b0;
    logic            SPI_SDO;
    logic            SPI_SDO_OE;
    logic [255:0]    regFile;
    logic            wrStrobe;
    logic [AW-1:0]   wrAddr;
    logic            frameError;
    logic [15:0]     frameCount;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_total     = 0;
    int err_total    = 0;

    logic [DW-1:0] model [NREG];

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        bit          exp_wr;
        bit          exp_err;
        logic [15:0] exp_rd;
        bit          chk_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    ami_spi_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .RESET_VALUE (16'h0000)
    ) dut (
        .sysClk     (sysClk),
        .sysReset   (sysReset),
        .SPI_CLK    (SPI_CLK),
        .SPI_CSB    (SPI_CSB),
        .SPI_SDI    (SPI_SDI),
        .SPI_SDO    (SPI_SDO),
        .SPI_SDO_OE (SPI_SDO_OE),
        .regFile    (regFile),
        .wrStrobe   (wrStrobe),
        .wrAddr     (wrAddr),
        .frameError (frameError),
        .frameCount (frameCount)
    );

    always #5 sysClk = ~sysClk;

    always @(negedge sysClk) begin
        if (wrStrobe)   wr_total++;
        if (frameError) err_total++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int r = 0; r < NREG; r++) f[r*DW +: DW] = model[r];
        return f;
    endfunction

    // Master side of one frame; rst_after > 0 pulses sysReset after that many bits.
    task automatic spi_frame(input logic [23:0] frame, input int nbits, input int rst_after,
                             output logic [31:0] miso, output logic late_sdo,
                             output logic oe_mid);
        miso     = '0;
        late_sdo = 1'b0;
        oe_mid   = 1'b0;
        @(negedge sysClk);
        SPI_CSB = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            SPI_SDI = (i < 24) ? frame[5'(23 - i)] : 1'b0;
            repeat (HALF) @(negedge sysClk);
            SPI_CLK = 1'b1;
            miso = {miso[30:0], SPI_SDO};
            if (i == 0) oe_mid = SPI_SDO_OE;
            repeat (HALF - 2) @(negedge sysClk);
            late_sdo = SPI_SDO;
            repeat (2) @(negedge sysClk);
            SPI_CLK = 1'b0;
            if (i == rst_after - 1) begin
                sysReset = 1'b1;
                repeat (3) @(negedge sysClk);
                sysReset = 1'b0;
            end
        end
        repeat (HALF) @(negedge sysClk);
        SPI_CSB = 1'b1;
        repeat (8) @(negedge sysClk);
    endtask

    initial begin
        logic [31:0] miso;
        logic        late;
        logic        oe_mid;
        int          wr0;
        int          err0;

        vecs[0]  = '{24'h03BEEF, 24, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
        vecs[1]  = '{24'h051234, 24, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd2};
        vecs[2]  = '{24'h850000, 24, 1'b0, 1'b0, 16'h1234, 1'b1, 16'd3};
        vecs[3]  = '{24'hFF0000, 24, 1'b0, 1'b0, 16'h0000, 1'b1, 16'd4};
        vecs[4]  = '{24'h205555, 24, 1'b0, 1'b0, 16'h0000, 1'b1, 16'd5};
        vecs[5]  = '{24'h02ABCD, 12, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd5};
        vecs[6]  = '{24'h830000, 24, 1'b0, 1'b0, 16'hBEEF, 1'b1, 16'd6};
        vecs[7]  = '{24'h017777, 25, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd6};
        vecs[8]  = '{24'h810000, 24, 1'b0, 1'b0, 16'h0000, 1'b1, 16'd7};
        vecs[9]  = '{24'h0FCAFE, 24, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd8};
        vecs[10] = '{24'h8F0000, 24, 1'b0, 1'b0, 16'hCAFE, 1'b1, 16'd9};
        vecs[11] = '{24'h101111, 24, 1'b0, 1'b0, 16'h0000, 1'b1, 16'd10};
        vecs[12] = '{24'h820000, 24, 1'b0, 1'b0, 16'h0000, 1'b1, 16'd11};

        for (int r = 0; r < NREG; r++) model[r] = 16'h0000;

        repeat (4) @(negedge sysClk);
        check("reset SDO",        256'(SPI_SDO),    256'(0));
        check("reset SDO_OE",     256'(SPI_SDO_OE), 256'(0));
        check("reset regFile",    regFile,          256'(0));
        check("reset wrStrobe",   256'(wrStrobe),   256'(0));
        check("reset wrAddr",     256'(wrAddr),     256'(0));
        check("reset frameError", 256'(frameError), 256'(0));
        check("reset frameCount", 256'(frameCount), 256'(0));
        sysReset = 1'b0;
        repeat (10) @(negedge sysClk);

        for (int k = 0; k < 13; k++) begin
            wr0  = wr_total;
            err0 = err_total;
            spi_frame(vecs[k].frame, vecs[k].nbits, -1, miso, late, oe_mid);
            if (vecs[k].exp_wr) model[vecs[k].frame[19:16]] = vecs[k].frame[15:0];
            check($sformatf("v%0d wrStrobe cycles", k), 256'(wr_total - wr0),
                  256'(vecs[k].exp_wr ? 1 : 0));
            check($sformatf("v%0d frameError cycles", k), 256'(err_total - err0),
                  256'(vecs[k].exp_err ? 1 : 0));
            check($sformatf("v%0d frameCount", k), 256'(frameCount), 256'(vecs[k].exp_cnt));
            check($sformatf("v%0d regFile", k), regFile, model_flat());
            check($sformatf("v%0d SDO_OE in frame", k), 256'(oe_mid), 256'(1));
            check($sformatf("v%0d SDO_OE after CSB", k), 256'(SPI_SDO_OE), 256'(0));
            if (vecs[k].exp_wr)
                check($sformatf("v%0d wrAddr", k), 256'(wrAddr), 256'(vecs[k].frame[19:16]));
            if (vecs[k].chk_rd)
                check($sformatf("v%0d SDO data", k), 256'(miso[15:0]), 256'(vecs[k].exp_rd));
            repeat (6) @(negedge sysClk);
        end

        // Overrun on a read: data still shifts out, SDO is 0 in the 25th bit.
        wr0  = wr_total;
        err0 = err_total;
        spi_frame(24'h830000, 25, -1, miso, late, oe_mid);
        check("ovr read data",      256'(miso[16:1]),         256'(16'hBEEF));
        check("ovr SDO in bit 25",  256'(late),               256'(0));
        check("ovr frameError",     256'(err_total - err0),   256'(1));
        check("ovr wrStrobe",       256'(wr_total - wr0),     256'(0));
        check("ovr frameCount",     256'(frameCount),         256'(16'd11));
        repeat (6) @(negedge sysClk);

        // Reset mid-frame, CSB still low at release: no decode of the tail.
        wr0  = wr_total;
        err0 = err_total;
        spi_frame(24'h04A5A5, 24, 10, miso, late, oe_mid);
        for (int r = 0; r < NREG; r++) model[r] = 16'h0000;
        check("rst-mid regFile",    regFile,                  model_flat());
        check("rst-mid frameCount", 256'(frameCount),         256'(0));
        check("rst-mid wrStrobe",   256'(wr_total - wr0),     256'(0));
        check("rst-mid frameError", 256'(err_total - err0),   256'(0));
        repeat (6) @(negedge sysClk);

        wr0  = wr_total;
        err0 = err_total;
        spi_frame(24'h04A5A5, 24, -1, miso, late, oe_mid);
        model[4] = 16'hA5A5;
        check("post-rst regFile",    regFile,                 model_flat());
        check("post-rst wrStrobe",   256'(wr_total - wr0),    256'(1));
        check("post-rst wrAddr",     256'(wrAddr),            256'(4));
        check("post-rst frameCount", 256'(frameCount),        256'(1));
        check("post-rst frameError", 256'(err_total - err0),  256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
